cla_seq_adder: RTL and testbench

Multi-cycle, parametrised add/subtract unit that runs an N-bit operation through a K-bit carry-lookahead slice, one chunk per clock, carrying between chunks in a register. It replaces the flat single-cycle CLA wherever wide operands, such as 64/128-bit accumulators, would break timing. It also adds subtract mode, overflow and zero flags, and a start/busy/done handshake.

---
 rtl/cla_seq_adder.sv | 142 ++++++++++++++
 tb/tb_cla_seq_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_adder
// Brief    : N-bit add/subtract sequenced through a K-bit carry-lookahead
//            slice, one chunk per clock, with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cla_seq_adder #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int C  = N / K;
    localparam int IW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_acc;
    logic [N-1:0]    w_acc_next;
    logic [K-1:0]    w_a_chunk;
    logic [K-1:0]    w_b_chunk;
    logic [K-1:0]    w_p;
    logic [K-1:0]    w_g;
    logic [K:0]      w_c;
    logic [K-1:0]    w_s;
    logic            w_last;
    logic            w_term;
    logic            w_any;

    assign w_last    = (r_idx == IW'(C - 1));
    assign w_a_chunk = r_a[int'(r_idx)*K +: K];
    assign w_b_chunk = r_b[int'(r_idx)*K +: K];
    assign w_p       = w_a_chunk ^ w_b_chunk;
    assign w_g       = w_a_chunk & w_b_chunk;
    assign w_s       = w_p ^ w_c[K-1:0];
    assign busy      = (r_state == ST_RUN);

    // Every slice carry is expanded as a sum of generate/propagate products
    // rooted at the registered carry, so no carry ripples within the slice.
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_any  = 1'b0;
        w_c[0] = r_carry;
        for (int i = 1; i <= K; i++) begin
            w_any = 1'b0;
            for (int j = 0; j < i; j++) begin
                w_term = w_g[j];
                for (int m = j + 1; m < i; m++) begin
                    w_term = w_term & w_p[m];
                end
                w_any = w_any | w_term;
            end
            w_term = r_carry;
            for (int m = 0; m < i; m++) begin
                w_term = w_term & w_p[m];
            end
            w_c[i] = w_any | w_term;
        end
    end

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[int'(r_idx)*K +: K] = w_s;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub | cin;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_c[K];
                    r_idx   <= w_last ? '0 : r_idx + IW'(1);
                    if (w_last) begin
                        sum  <= w_acc_next;
                        cout <= w_c[K];
                        ovf  <= w_c[K-1] ^ w_c[K];
                        zero <= ~|w_acc_next;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_seq_adder
// Brief    : Scoreboard bench for cla_seq_adder (K=8 and K=32 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_seq_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy0, done0, cout0, ovf0, zero0;
    logic        busy1, done1, cout1, ovf1, zero1;
    logic [31:0] sum0, sum1;

    res_t sb0[$];
    res_t sb1[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   done_cnt0    = 0;
    int   done_cnt1    = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.N(32), .K(8)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0), .zero(zero0)
    );

    cla_seq_adder #(.N(32), .K(32)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    function automatic res_t model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                   input logic ci);
        logic [31:0] yy;
        logic [32:0] t;
        res_t        r;
        yy     = s ? ~y : y;
        t      = {1'b0, x} + {1'b0, yy} + {32'd0, (s ? 1'b1 : ci)};
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (x[31] == yy[31]) && (t[31] != x[31]);
        r.zero = (t[31:0] == 32'd0);
        return r;
    endfunction

    // Scoreboard: each done pulse pops the oldest expected result.
    always @(negedge clk) begin
        res_t e0, g0;
        if (done0) begin
            done_cnt0++;
            n_compared++;
            g0 = '{sum0, cout0, ovf0, zero0};
            if (sb0.size() == 0) begin
                n_mismatched++;
                $display("FAIL sb0_unexpected_done got sum=%h cout=%b ovf=%b zero=%b", sum0, cout0, ovf0, zero0);
            end else begin
                e0 = sb0.pop_front();
                if (g0 !== e0) begin
                    n_mismatched++;
                    $display("FAIL sb0_result got sum=%h cout=%b ovf=%b zero=%b exp sum=%h cout=%b ovf=%b zero=%b",
                             g0.sum, g0.cout, g0.ovf, g0.zero, e0.sum, e0.cout, e0.ovf, e0.zero);
                end
            end
        end
    end

    always @(negedge clk) begin
        res_t e1, g1;
        if (done1) begin
            done_cnt1++;
            n_compared++;
            g1 = '{sum1, cout1, ovf1, zero1};
            if (sb1.size() == 0) begin
                n_mismatched++;
                $display("FAIL sb1_unexpected_done got sum=%h", sum1);
            end else begin
                e1 = sb1.pop_front();
                if (g1 !== e1) begin
                    n_mismatched++;
                    $display("FAIL sb1_result got sum=%h cout=%b ovf=%b zero=%b exp sum=%h cout=%b ovf=%b zero=%b",
                             g1.sum, g1.cout, g1.ovf, g1.zero, e1.sum, e1.cout, e1.ovf, e1.zero);
                end
            end
        end
    end

    // Presents one start cycle, then scrambles inputs to prove capture.
    task automatic issue(input bit which, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic ci);
        @(negedge clk);
        sub = s; a = x; b = y; cin = ci;
        if (which) begin start1 = 1'b1; sb1.push_back(model(s, x, y, ci)); end
        else       begin start0 = 1'b1; sb0.push_back(model(s, x, y, ci)); end
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    endtask

    task automatic run_op(input string name, input bit which, input logic s,
                          input logic [31:0] x, input logic [31:0] y, input logic ci,
                          input int exp_lat);
        int lat;
        issue(which, s, x, y, ci);
        lat = 0;
        while (!(which ? done1 : done0) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_compared++;
        if (lat !== exp_lat) begin
            n_mismatched++;
            $display("FAIL %s_latency got %0d exp %0d", name, lat, exp_lat);
        end
        @(negedge clk);
        n_compared++;
        if ((which ? done1 : done0) !== 1'b0) begin
            n_mismatched++;
            $display("FAIL %s_done_width got done=1 exp 0 one cycle after pulse", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_compared++;
        if ({busy0, done0, sum0, cout0, ovf0, zero0} !== {1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL reset0 got busy=%b done=%b sum=%h cout=%b ovf=%b zero=%b exp 0 0 0 0 0 1",
                     busy0, done0, sum0, cout0, ovf0, zero0);
        end
        n_compared++;
        if ({busy1, done1, sum1, zero1} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL reset1 got busy=%b done=%b sum=%h zero=%b exp 0 0 0 1", busy1, done1, sum1, zero1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_flags;
        run_op("wrap", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4);
        run_op("add_ovf", 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4);
        run_op("add_mix", 1'b0, 1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 4);
    endtask

    task automatic test_subtract;
        run_op("sub_neg", 1'b0, 1'b1, 32'd5, 32'd9, 1'b0, 4);
        run_op("sub_ovf", 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 4);
        run_op("sub_eq", 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4);
    endtask

    task automatic test_handshake;
        int busy_cnt;
        int d;
        d = done_cnt0;
        issue(1'b0, 1'b0, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
        busy_cnt = 0;
        while (busy0 && busy_cnt < 20) begin
            if (busy_cnt == 1) begin
                start0 = 1'b1; a = 32'h1111_1111; b = 32'h2222_2222;
            end else begin
                start0 = 1'b0;
            end
            @(negedge clk);
            busy_cnt++;
        end
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        n_compared++;
        if (busy_cnt !== 4) begin
            n_mismatched++;
            $display("FAIL hs_busy_cycles got %0d exp 4", busy_cnt);
        end
        n_compared++;
        if (done_cnt0 - d !== 1) begin
            n_mismatched++;
            $display("FAIL hs_done_count got %0d exp 1", done_cnt0 - d);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        start0 = 1'b1; sub = 1'b0; a = 32'h0000_0010; b = 32'h0000_0020; cin = 1'b0;
        sb0.push_back(model(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0));
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        sb0.push_back(model(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
        lat = 0;
        while (!done0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        start0 = 1'b0;
        n_compared++;
        if (busy0 !== 1'b1) begin
            n_mismatched++;
            $display("FAIL b2b_accept got busy=%b exp 1 after done cycle", busy0);
        end
        lat = 0;
        while (!done0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_compared++;
        if (lat !== 4) begin
            n_mismatched++;
            $display("FAIL b2b_latency got %0d exp 4", lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int d;
        issue(1'b0, 1'b0, 32'h0000_1234, 32'h0000_4321, 1'b0);
        @(negedge clk);
        d = done_cnt0;
        #1 rst = 1'b1;
        #1;
        n_compared++;
        if ({busy0, done0, sum0, zero0} !== {1'b0, 1'b0, 32'd0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL midrst got busy=%b done=%b sum=%h zero=%b exp 0 0 0 1", busy0, done0, sum0, zero0);
        end
        sb0.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        n_compared++;
        if (done_cnt0 !== d) begin
            n_mismatched++;
            $display("FAIL midrst_no_done got %0d pulses exp 0", done_cnt0 - d);
        end
        run_op("post_rst", 1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 4);
    endtask

    task automatic test_single_chunk;
        run_op("c1_wrap", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
        run_op("c1_sub", 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1);
    endtask

    initial begin
        test_reset;
        test_add_flags;
        test_subtract;
        test_handshake;
        test_back_to_back;
        test_reset_mid;
        test_single_chunk;
        repeat (2) @(negedge clk);
        n_compared++;
        if (sb0.size() + sb1.size() !== 0) begin
            n_mismatched++;
            $display("FAIL sb_drain got %0d pending exp 0", sb0.size() + sb1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
